// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and ID width.
// The ID state exists only when UART_TX_SCHED_ID_PREFIX_EN is defined.
package uart_tx_sched_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);

    // Width of a requester index; also the payload of the optional ID byte.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef UART_TX_SCHED_ID_PREFIX_EN
        ST_ID    = 3'd4,
`endif
        ST_SEND  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3
    } state_t;

endpackage

// File: rtl/uart_tx_sched_rr.sv
// Round-robin picker: returns the first requesting index at or after ptr, wrapping.
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned N     = NUM_REQ_DEF,
    parameter int unsigned PTR_W = id_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner_c
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        winner_c = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                winner_c[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules whole messages from NUM_REQ requesters onto one shared UART transmitter.
// Define UART_TX_SCHED_ID_PREFIX_EN to precede every message with its requester index byte.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_ready
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    state_t               state;
    state_t               next_state;
    logic [NUM_REQ-1:0]   winner;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      gidx;
    logic                 last_q;
    logic                 gvalid;
    logic                 glast;
    logic [DATA_BITS-1:0] gdata;
    logic                 xfer_c;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (ptr),
        .winner_c (winner)
    );

    // Index and request fields of the current message owner.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gidx = ID_W'(i);
        end
    end

    assign gvalid = |(req_valid & grant);
    assign glast  = req_last[gidx];
    assign gdata  = req_data[32'(gidx)*DATA_BITS +: DATA_BITS];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= ST_IDLE;
        else          state <= next_state;
    end

    // tx_start is high exactly in the first WAIT cycle, when tx_ready has not yet fallen.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
`ifdef UART_TX_SCHED_ID_PREFIX_EN
                    next_state = ST_ID;
`else
                    next_state = ST_SEND;
`endif
                end
            end
`ifdef UART_TX_SCHED_ID_PREFIX_EN
            ST_ID:    if (tx_ready) next_state = ST_ISSUE;
`endif
            ST_SEND:  if (tx_ready && gvalid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (!tx_start && tx_ready) next_state = last_q ? ST_IDLE : ST_SEND;
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        xfer_c    = 1'b0;
        req_ready = '0;
        if (state == ST_SEND && tx_ready && gvalid) begin
            xfer_c    = 1'b1;
            req_ready = grant;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            grant    <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            last_q   <= 1'b0;
            ptr      <= '0;
        end else begin
            tx_start <= (state == ST_ISSUE);
            busy     <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: if (|req_valid) grant <= winner;
`ifdef UART_TX_SCHED_ID_PREFIX_EN
                ST_ID: begin
                    if (tx_ready) begin
                        tx_data <= DATA_BITS'(gidx);
                        last_q  <= 1'b0;
                    end
                end
`endif
                ST_SEND: begin
                    if (xfer_c) begin
                        tx_data <= gdata;
                        last_q  <= glast;
                    end
                end
                ST_WAIT: begin
                    if (next_state == ST_IDLE) begin
                        grant <= '0;
                        ptr   <= (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
